// File: rtl/rng_mine_placer.sv
// rng_mine_placer
//   Places exactly min(in_mines_num, MAXM) distinct mines on a ROWS x COLS board.
//   A registered LCG draws one candidate cell per mine. If that cell is taken,
//   the probe pointer walks linearly (with wrap) until it finds a free cell.
//   One placement decision is made per clock. Control is a start/busy/done handshake.
//
//   Optional feature macro: RNG_MINE_PLACER_SAFE_CELL_EN
//     defined   -> in_safe_idx exists and is latched at start. That cell is treated as
//                  occupied but is never reported as a mine. MAXM = CELLS-1.
//     undefined -> every cell is eligible. MAXM = CELLS.
//
// Ports
//   in_clka       clock, all logic on posedge
//   in_reset      synchronous active-high reset
//   in_start      start request, only honoured in IDLE
//   in_seed       LCG start value X0
//   in_mult       LCG multiplier a (latched)
//   in_increment  LCG increment c (latched)
//   in_mines_num  requested mine count (clamped to MAXM, latched)
//   in_safe_idx   never-mined cell (macro builds only)
//   out_mines     bit i set -> mine at cell i (row-major, i = r*COLS + c)
//   out_busy      high while placing
//   out_done      one-cycle completion pulse
//   out_placed    number of mines placed so far
module rng_mine_placer #(
  parameter int ROWS   = 5,
  parameter int COLS   = 5,
  parameter int SEED_W = 16,
  localparam int CELLS = ROWS * COLS,
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1,
  localparam int CNT_W = $clog2(CELLS + 1)
) (
  input  logic              in_clka,
  input  logic              in_reset,
  input  logic              in_start,
  input  logic [SEED_W-1:0] in_seed,
  input  logic [SEED_W-1:0] in_mult,
  input  logic [SEED_W-1:0] in_increment,
  input  logic [CNT_W-1:0]  in_mines_num,
`ifdef RNG_MINE_PLACER_SAFE_CELL_EN
  input  logic [IDX_W-1:0]  in_safe_idx,
`endif
  output logic [CELLS-1:0]  out_mines,
  output logic              out_busy,
  output logic              out_done,
  output logic [CNT_W-1:0]  out_placed
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

`ifdef RNG_MINE_PLACER_SAFE_CELL_EN
  localparam logic [CNT_W-1:0] MAXM = CNT_W'(CELLS - 1);
`else
  localparam logic [CNT_W-1:0] MAXM = CNT_W'(CELLS);
`endif

  state_t             state_q, state_d;
  logic [SEED_W-1:0]  lcg_q, lcg_d;
  logic [SEED_W-1:0]  mult_q, mult_d;
  logic [SEED_W-1:0]  incr_q, incr_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [IDX_W-1:0]   probe_q, probe_d;
  logic [CELLS-1:0]   mines_q, mines_d;
  logic [CNT_W-1:0]   placed_q, placed_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef RNG_MINE_PLACER_SAFE_CELL_EN
  logic [IDX_W-1:0]   safe_q, safe_d;
`endif

  // Product deliberately truncated to SEED_W bits (mod 2^SEED_W).
  function automatic logic [SEED_W-1:0] lcg_next(input logic [SEED_W-1:0] a,
                                                 input logic [SEED_W-1:0] x,
                                                 input logic [SEED_W-1:0] c);
    logic [SEED_W-1:0] r;
    r = a * x + c;
    return r;
  endfunction

  // Scale the top byte of the LCG state onto 0..CELLS-1 without a divider.
  function automatic logic [IDX_W-1:0] cell_idx(input logic [SEED_W-1:0] x);
    logic [15:0] scaled;
    scaled = 16'(x[SEED_W-1 -: 8]) * 16'(CELLS);
    return IDX_W'(scaled[15:8]);
  endfunction

  logic              cell_free;
  logic [SEED_W-1:0] lcg_adv;
  logic [SEED_W-1:0] lcg_first;

  always_comb begin
    state_d   = state_q;
    lcg_d     = lcg_q;
    mult_d    = mult_q;
    incr_d    = incr_q;
    target_d  = target_q;
    probe_d   = probe_q;
    mines_d   = mines_q;
    placed_d  = placed_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef RNG_MINE_PLACER_SAFE_CELL_EN
    safe_d    = safe_q;
    cell_free = (mines_q[probe_q] == 1'b0) && (probe_q != safe_q);
`else
    cell_free = (mines_q[probe_q] == 1'b0);
`endif
    lcg_adv   = lcg_next(mult_q, lcg_q, incr_q);
    lcg_first = lcg_next(in_mult, in_seed, in_increment);

    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          mult_d   = in_mult;
          incr_d   = in_increment;
          target_d = (in_mines_num > MAXM) ? MAXM : in_mines_num;
`ifdef RNG_MINE_PLACER_SAFE_CELL_EN
          safe_d   = in_safe_idx;
`endif
          lcg_d    = lcg_first;
          probe_d  = cell_idx(lcg_first);
          mines_d  = '0;
          placed_d = '0;
          busy_d   = 1'b1;
          state_d  = S_DRAW;
        end
      end
      S_DRAW: begin
        if (placed_q == target_q) begin
          state_d = S_DONE;
        end else if (cell_free) begin
          mines_d[probe_q] = 1'b1;
          placed_d = placed_q + CNT_W'(1);
          lcg_d    = lcg_adv;
          probe_d  = cell_idx(lcg_adv);
        end else begin
          // Collision: keep the LCG, step the probe with wrap-around.
          probe_d = (probe_q == IDX_W'(CELLS - 1)) ? '0 : probe_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clka) begin
    if (in_reset) begin
      state_q  <= S_IDLE;
      lcg_q    <= '0;
      mult_q   <= '0;
      incr_q   <= '0;
      target_q <= '0;
      probe_q  <= '0;
      mines_q  <= '0;
      placed_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef RNG_MINE_PLACER_SAFE_CELL_EN
      safe_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lcg_q    <= lcg_d;
      mult_q   <= mult_d;
      incr_q   <= incr_d;
      target_q <= target_d;
      probe_q  <= probe_d;
      mines_q  <= mines_d;
      placed_q <= placed_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef RNG_MINE_PLACER_SAFE_CELL_EN
      safe_q   <= safe_d;
`endif
    end
  end

  assign out_mines  = mines_q;
  assign out_busy   = busy_q;
  assign out_done   = done_q;
  assign out_placed = placed_q;

endmodule

// File: tb/tb_rng_mine_placer.sv
// Testbench for rng_mine_placer (ROWS=COLS=5, SEED_W=16).
// The reference model replays the placement rules with plain integer arithmetic.
// It predicts the final board, the mine count and the completion cycle.
module tb_rng_mine_placer;
  localparam int CELLS  = 25;
  localparam int SEED_W = 16;
  localparam int IDX_W  = 5;
  localparam int CNT_W  = 5;
`ifdef RNG_MINE_PLACER_SAFE_CELL_EN
  localparam int MAXM = CELLS - 1;
`else
  localparam int MAXM = CELLS;
`endif

  logic              clk = 1'b0;
  logic              in_reset = 1'b1;
  logic              in_start = 1'b0;
  logic [SEED_W-1:0] in_seed = '0;
  logic [SEED_W-1:0] in_mult = '0;
  logic [SEED_W-1:0] in_increment = '0;
  logic [CNT_W-1:0]  in_mines_num = '0;
  logic [IDX_W-1:0]  in_safe_idx = '0;
  logic [CELLS-1:0]  out_mines;
  logic              out_busy;
  logic              out_done;
  logic [CNT_W-1:0]  out_placed;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rng_mine_placer #(.ROWS(5), .COLS(5), .SEED_W(16)) dut (
    .in_clka      (clk),
    .in_reset     (in_reset),
    .in_start     (in_start),
    .in_seed      (in_seed),
    .in_mult      (in_mult),
    .in_increment (in_increment),
    .in_mines_num (in_mines_num),
`ifdef RNG_MINE_PLACER_SAFE_CELL_EN
    .in_safe_idx  (in_safe_idx),
`endif
    .out_mines    (out_mines),
    .out_busy     (out_busy),
    .out_done     (out_done),
    .out_placed   (out_placed)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Board, target and total probe count (one DRAW cycle per probe) predicted from the rules.
  function automatic void model(input int seed, input int a, input int c, input int n,
                                input int safe, output logic [CELLS-1:0] mines,
                                output int probes, output int tgt);
    longint x;
    int p;
    bit occ[CELLS];
    int safe_eff;
`ifdef RNG_MINE_PLACER_SAFE_CELL_EN
    safe_eff = safe;
`else
    safe_eff = -1;
`endif
    foreach (occ[i]) occ[i] = 1'b0;
    tgt = (n > MAXM) ? MAXM : n;
    mines = '0;
    probes = 0;
    x = seed;
    for (int k = 0; k < tgt; k++) begin
      x = (longint'(a) * x + c) % 65536;
      p = int'(((x >> 8) * CELLS) >> 8);
      probes++;
      while (occ[p] || p == safe_eff) begin
        p = (p + 1) % CELLS;
        probes++;
      end
      occ[p] = 1'b1;
      mines[p] = 1'b1;
    end
  endfunction

  // One placement run. restart_at >= 0 pulses start again mid-run.
  // With scramble set, the inputs are randomised every cycle after the start edge.
  task automatic do_run(input string name, input int seed, input int a, input int c,
                        input int n, input int safe, input int restart_at, input bit scramble);
    logic [CELLS-1:0] em;
    int ep, tgt, cyc;
    bit seen;
    model(seed, a, c, n, safe, em, ep, tgt);
    @(negedge clk);
    in_seed = SEED_W'(seed);
    in_mult = SEED_W'(a);
    in_increment = SEED_W'(c);
    in_mines_num = CNT_W'(n);
    in_safe_idx = IDX_W'(safe);
    in_start = 1'b1;
    @(posedge clk);
    #1;
    in_start = 1'b0;
    cyc = 0;
    seen = 1'b0;
    check({name, "_busy_c0"}, out_busy, 1);
    while (!seen && cyc < 2000) begin
      if (scramble) begin
        in_seed = SEED_W'($urandom);
        in_mult = SEED_W'($urandom);
        in_increment = SEED_W'($urandom);
        in_mines_num = CNT_W'($urandom);
        in_safe_idx = IDX_W'($urandom_range(0, CELLS - 1));
      end
      in_start = (cyc == restart_at);
      @(posedge clk);
      #1;
      cyc++;
      if (out_done) seen = 1'b1;
    end
    in_start = 1'b0;
    check({name, "_done_cycle"}, cyc, ep + 2);
    check({name, "_mines"}, out_mines, em);
    check({name, "_placed"}, out_placed, tgt);
    check({name, "_popcount"}, $countones(out_mines), tgt);
    check({name, "_within_bound"}, (cyc <= n * CELLS + 2), 1);
    check({name, "_busy_at_done"}, out_busy, 0);
    @(posedge clk);
    #1;
    check({name, "_done_one_cycle"}, out_done, 0);
    check({name, "_mines_hold"}, out_mines, em);
    $display("run %s seed=%0h a=%0h c=%0h n=%0d cycles=%0d mines=%07h", name, seed, a, c, n, cyc, out_mines);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_mines", out_mines, 0);
    check("rst_busy", out_busy, 0);
    check("rst_done", out_done, 0);
    check("rst_placed", out_placed, 0);
    in_reset = 1'b0;

    // Safe cell parked at 24 so it does not disturb the low-cell directed cases.
    do_run("t1", 0, 1, 0, 3, 24, -1, 1'b0);
    check("t1_mines_const", out_mines, 25'h0000007);
    do_run("t2_zero", 0, 1, 0, 0, 24, -1, 1'b0);
    check("t2_mines_const", out_mines, 0);
    do_run("t3_clamp", 0, 1, 0, 30, 24, -1, 1'b0);
`ifdef RNG_MINE_PLACER_SAFE_CELL_EN
    check("t3_mines_const", out_mines, 25'h0FFFFFF);
`else
    check("t3_mines_const", out_mines, 25'h1FFFFFF);
`endif
    do_run("t4_restart", 0, 1, 0, 3, 24, 3, 1'b0);
    check("t4_mines_const", out_mines, 25'h0000007);

    // Reset in the middle of a placement.
    @(negedge clk);
    in_seed = '0; in_mult = 16'd1; in_increment = '0; in_mines_num = 5'd3;
    in_start = 1'b1;
    @(posedge clk);
    #1;
    in_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    in_reset = 1'b1;
    @(posedge clk);
    #1;
    in_reset = 1'b0;
    check("midrst_mines", out_mines, 0);
    check("midrst_busy", out_busy, 0);
    check("midrst_done", out_done, 0);
    check("midrst_placed", out_placed, 0);
    do_run("t4_after_reset", 0, 1, 0, 3, 24, -1, 1'b0);

`ifdef RNG_MINE_PLACER_SAFE_CELL_EN
    do_run("t5_safe", 0, 1, 0, 2, 0, -1, 1'b0);
    check("t5_mines_const", out_mines, 25'h0000006);
    do_run("t5_safe_clamp", 0, 1, 0, 25, 0, -1, 1'b0);
    check("t5_clamp_const", out_mines, 25'h1FFFFFE);
`endif

    for (int r = 0; r < 300; r++) begin
      do_run($sformatf("rnd%0d", r), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 30)), int'($urandom_range(0, CELLS - 1)),
             int'($urandom_range(1, 12)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
